tattr_dma: RTL and testbench

- CPU-programmed copy engine that moves a block of bytes from system memory into the video unit's tile-attribute RAM write port.
- Sits directly upstream of the video unit, sharing its `wclk` domain, so a whole 28x19 tile map (532 bytes) can be loaded without a CPU store per tile.
- Configured through four 32-bit registers on the peripheral bus.
- Reads source bytes over a req/ready handshake and issues one tile-attribute write per byte.

---
 rtl/tattr_dma.sv | 214 +++++++++++++++++++++
 tb/tb_tattr_dma.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tattr_dma.sv
// ---------------------------------------------------------------------------
// tattr_dma
//
// CPU-programmed copy engine that streams a block of bytes from system memory
// into the video unit's tile-attribute RAM write port. It runs in the video
// unit's wclk domain, so a whole tile map can be loaded without one CPU store
// per tile.
//
// Ports:
//   clk, rst_n     clock (video wclk) and asynchronous active-low reset
//   cfg_addr       register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL
//   cfg_wdata      register write data
//   cfg_wenable    register write strobe
//   cfg_rdata      register read data, combinational from cfg_addr
//   mem_addr       source byte address
//   mem_req        read request, held until mem_ready
//   mem_ready      read accepted, mem_rdata valid in the same cycle
//   mem_rdata      source byte
//   tattr_addr     tile-attribute write address
//   tattr_wdata    tile-attribute write data
//   tattr_wenable  tile-attribute write strobe
//   in_vblank      display is outside the visible area
//   irq            level interrupt, mirrors the done flag
//
// CTRL write: bit0 start, bit1 abort, bit2 irq-ack.
// CTRL read : bit0 busy,  bit1 done.
//
// Optional feature macro: TATTR_DMA_VBLANK_GATE_EN
//   When defined, new memory requests are only launched while in_vblank is
//   high; otherwise the engine parks in HOLD (busy, no request).
// ---------------------------------------------------------------------------
module tattr_dma #(
  parameter int ATTR_AW = 10,
  parameter int LEN_W   = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  input  logic               cfg_wenable,
  output logic [31:0]        cfg_rdata,
  output logic [31:0]        mem_addr,
  output logic               mem_req,
  input  logic               mem_ready,
  input  logic [7:0]         mem_rdata,
  output logic [ATTR_AW-1:0] tattr_addr,
  output logic [7:0]         tattr_wdata,
  output logic               tattr_wenable,
  input  logic               in_vblank,
  output logic               irq
);

  typedef enum logic [2:0] {IDLE, REQ, WRITE, FINISH, HOLD} state_t;

  localparam logic [LEN_W-1:0]   LEN_ONE = LEN_W'(1);
  localparam logic [ATTR_AW-1:0] DST_ONE = ATTR_AW'(1);

  state_t state;
  state_t next_state;
  state_t req_target;

  logic [31:0]        src_cnt;
  logic [ATTR_AW-1:0] dst_cnt;
  logic [LEN_W-1:0]   len_cnt;
  logic [7:0]         wdata_q;
  logic               done;

  logic ctrl_wr;
  logic ctrl_start;
  logic ctrl_abort;
  logic ctrl_ack;
  logic start_ok;
  logic vblank_ok;
  logic busy;

  assign ctrl_wr    = cfg_wenable && (cfg_addr == 2'd3);
  assign ctrl_start = ctrl_wr && cfg_wdata[0];
  assign ctrl_abort = ctrl_wr && cfg_wdata[1];
  assign ctrl_ack   = ctrl_wr && cfg_wdata[2];
  assign busy       = (state != IDLE);

`ifdef TATTR_DMA_VBLANK_GATE_EN
  assign vblank_ok = in_vblank;
`else
  logic unused_vblank;
  assign unused_vblank = in_vblank;
  assign vblank_ok     = 1'b1;
`endif

  // Launching a new request goes to REQ when allowed, else parks in HOLD.
  assign req_target = vblank_ok ? REQ : HOLD;

  assign mem_addr    = src_cnt;
  assign tattr_addr  = dst_cnt;
  assign tattr_wdata = wdata_q;
  assign irq         = done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode. Abort beats start in the same CTRL write,
  // and an abort seen in WRITE still lets that one write complete.
  always_comb begin
    next_state    = state;
    mem_req       = 1'b0;
    tattr_wenable = 1'b0;
    start_ok      = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_start && !ctrl_abort) begin
          start_ok = 1'b1;
          if (len_cnt == '0) begin
            next_state = FINISH;
          end else begin
            next_state = req_target;
          end
        end
      end
      HOLD: begin
        if (ctrl_abort) begin
          next_state = IDLE;
        end else if (vblank_ok) begin
          next_state = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (ctrl_abort) begin
          next_state = IDLE;
        end else if (mem_ready) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        tattr_wenable = 1'b1;
        if (ctrl_abort) begin
          next_state = IDLE;
        end else if (len_cnt == LEN_ONE) begin
          next_state = FINISH;
        end else begin
          next_state = req_target;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The programmed registers double as the working counters, so reads while
  // busy show live progress. CPU writes land only when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_cnt <= '0;
      dst_cnt <= '0;
      len_cnt <= '0;
    end else if (state == IDLE) begin
      if (cfg_wenable) begin
        case (cfg_addr)
          2'd0:    src_cnt <= cfg_wdata;
          2'd1:    dst_cnt <= cfg_wdata[ATTR_AW-1:0];
          2'd2:    len_cnt <= cfg_wdata[LEN_W-1:0];
          default: ;
        endcase
      end
    end else if (state == WRITE) begin
      src_cnt <= src_cnt + 32'd1;
      dst_cnt <= dst_cnt + DST_ONE;
      len_cnt <= len_cnt - LEN_ONE;
    end
  end

  // Capture the source byte on the accepting cycle of a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q <= '0;
    end else if (state == REQ && mem_ready) begin
      wdata_q <= mem_rdata;
    end
  end

  // Done is set only by a completed transfer; an ack or an accepted start
  // clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if (state == FINISH) begin
      done <= 1'b1;
    end else if (start_ok || ctrl_ack) begin
      done <= 1'b0;
    end
  end

  // Register read mux.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata = src_cnt;
      2'd1:    cfg_rdata = {{(32-ATTR_AW){1'b0}}, dst_cnt};
      2'd2:    cfg_rdata = {{(32-LEN_W){1'b0}}, len_cnt};
      default: cfg_rdata = {30'd0, done, busy};
    endcase
  end

endmodule

// File: tb/tb_tattr_dma.sv
// ---------------------------------------------------------------------------
// tb_tattr_dma
//
// Directed bench for tattr_dma. A transfer-level model (queue of expected
// source address / destination address / byte per transfer) is filled when a
// transfer is programmed; one monitor process compares every memory request
// and every tile-attribute write against the head of that queue. A simple
// memory responder answers requests after a programmable delay with
// byte = 0xA0 + low byte of the address.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tattr_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_wenable;
  logic [31:0] cfg_rdata;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic [9:0]  tattr_addr;
  logic [7:0]  tattr_wdata;
  logic        tattr_wenable;
  logic        in_vblank;
  logic        irq;

  typedef struct {
    logic [31:0] src;
    logic [9:0]  dst;
    logic [7:0]  data;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] wlog[$];
  int          wcyc[$];
  int          req_runs[$];
  int          n_compared = 0;
  int          n_mismatched = 0;
  int          n_writes = 0;
  int          cycle = 0;
  int          req_run = 0;
  int          ready_delay = 0;
  int          rsp_cnt = 0;

  tattr_dma #(.ATTR_AW(10), .LEN_W(11)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_wenable   (cfg_wenable),
    .cfg_rdata     (cfg_rdata),
    .mem_addr      (mem_addr),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .tattr_addr    (tattr_addr),
    .tattr_wdata   (tattr_wdata),
    .tattr_wenable (tattr_wenable),
    .in_vblank     (in_vblank),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Memory responder: raises ready after ready_delay waiting cycles.
  always @(negedge clk) begin
    if (mem_req && rst_n) begin
      mem_rdata = 8'hA0 + mem_addr[7:0];
      if (rsp_cnt == ready_delay) begin
        mem_ready = 1'b1;
        rsp_cnt   = 0;
      end else begin
        mem_ready = 1'b0;
        rsp_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      rsp_cnt   = 0;
    end
  end

  // Monitor: every request and every write must match the model queue head.
  always @(posedge clk) begin
    #1;
    cycle++;
    if (rst_n) begin
      if (mem_req) begin
        req_run++;
        if (exp_q.size() == 0) begin
          checkOutput("spurious_mem_req", 32'(mem_req), 32'd0);
        end else begin
          checkOutput("mem_addr", mem_addr, exp_q[0].src);
        end
      end else if (req_run != 0) begin
        req_runs.push_back(req_run);
        req_run = 0;
      end
      if (tattr_wenable) begin
        n_writes++;
        wcyc.push_back(cycle);
        wlog.push_back({14'd0, tattr_addr, tattr_wdata});
        if (exp_q.size() == 0) begin
          checkOutput("spurious_tattr_write", 32'(tattr_wenable), 32'd0);
        end else begin
          checkOutput("tattr_addr", 32'(tattr_addr), 32'(exp_q[0].dst));
          checkOutput("tattr_wdata", 32'(tattr_wdata), 32'(exp_q[0].data));
          void'(exp_q.pop_front());
        end
      end
    end else begin
      req_run = 0;
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_addr    = a;
    cfg_wdata   = d;
    cfg_wenable = 1'b1;
    @(negedge clk);
    cfg_wenable = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic wait_writes(input int target, input int budget);
    int k = 0;
    while (n_writes < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_writes < target) checkOutput("write_wait_timeout", 32'(n_writes), 32'(target));
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] r;
    int k = 0;
    do begin
      @(negedge clk);
      cfg_read(2'd3, r);
      k++;
    end while (r[0] && k < budget);
    if (r[0]) checkOutput("idle_timeout", 32'(r[0]), 32'd0);
  endtask

  // Program SRC/DST/LEN, load the model with the expected transfers, then
  // write CTRL with the given value.
  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d,
                               input logic [31:0] l, input int delay,
                               input logic [31:0] ctrl);
    xfer_t       e;
    logic [31:0] a;
    logic [31:0] t;
    ready_delay = delay;
    cfg_write(2'd0, s);
    cfg_write(2'd1, d);
    cfg_write(2'd2, l);
    for (int unsigned i = 0; i < l; i++) begin
      a      = s + i;
      t      = (d + i) % 1024;
      e.src  = a;
      e.dst  = t[9:0];
      e.data = 8'hA0 + a[7:0];
      exp_q.push_back(e);
    end
    cfg_write(2'd3, ctrl);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] r;
    int          base;

    rst_n       = 1'b0;
    cfg_addr    = 2'd0;
    cfg_wdata   = 32'd0;
    cfg_wenable = 1'b0;
    mem_ready   = 1'b0;
    mem_rdata   = 8'd0;
    in_vblank   = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_strobes", {29'd0, mem_req, tattr_wenable, irq}, 32'd0);
    checkOutput("reset_tattr", {14'd0, tattr_addr, tattr_wdata}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_read(2'd3, r);
    checkOutput("reset_ctrl", r, 32'd0);
    cfg_read(2'd2, r);
    checkOutput("reset_len", r, 32'd0);

    // Basic 4-byte copy, ready held high.
    $display("[TB] basic copy");
    base = n_writes;
    wcyc.delete();
    wlog.delete();
    req_runs.delete();
    applyStimulus(32'h1000, 32'd0, 32'd4, 0, 32'd1);
    wait_idle(40);
    checkOutput("basic_writes", 32'(n_writes - base), 32'd4);
    checkOutput("basic_first", wlog[0], 32'h000A0);
    checkOutput("basic_last", wlog[3], 32'h003A3);
    for (int i = 1; i < 4; i++) checkOutput("basic_spacing", 32'(wcyc[i] - wcyc[i-1]), 32'd2);
    cfg_read(2'd3, r);
    checkOutput("basic_ctrl_done", r, 32'd2);
    checkOutput("basic_irq", 32'(irq), 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("basic_req_runs", 32'(req_runs.size()), 32'd4);

    // Zero length: straight to done, no traffic.
    $display("[TB] zero length");
    cfg_write(2'd3, 32'd4);
    checkOutput("ack_clears_irq", 32'(irq), 32'd0);
    base = n_writes;
    applyStimulus(32'h1800, 32'd5, 32'd0, 0, 32'd1);
    cfg_read(2'd3, r);
    checkOutput("zero_len_finish", r, 32'd1);
    @(negedge clk);
    cfg_read(2'd3, r);
    checkOutput("zero_len_done", r, 32'd2);
    checkOutput("zero_len_writes", 32'(n_writes - base), 32'd0);

    // Destination wrap at 1024.
    $display("[TB] destination wrap");
    base = n_writes;
    wlog.delete();
    applyStimulus(32'h2000, 32'd1022, 32'd3, 0, 32'd1);
    wait_idle(40);
    checkOutput("wrap_writes", 32'(n_writes - base), 32'd3);
    checkOutput("wrap_w0", wlog[0], 32'h3FEA0);
    checkOutput("wrap_w1", wlog[1], 32'h3FFA1);
    checkOutput("wrap_w2", wlog[2], 32'h000A2);
    cfg_read(2'd1, r);
    checkOutput("wrap_dst_readback", r, 32'd1);
    cfg_read(2'd0, r);
    checkOutput("wrap_src_readback", r, 32'h2003);

    // Slow memory: 5 wait cycles per byte; busy-time writes are ignored.
    $display("[TB] slow memory");
    base = n_writes;
    req_runs.delete();
    applyStimulus(32'h3010, 32'd100, 32'd2, 5, 32'd1);
    wait_writes(base + 1, 40);
    cfg_write(2'd0, 32'hDEAD0000);
    cfg_write(2'd3, 32'd1);
    cfg_read(2'd2, r);
    checkOutput("slow_live_len", r, 32'd1);
    wait_idle(60);
    @(negedge clk);
    checkOutput("slow_writes", 32'(n_writes - base), 32'd2);
    checkOutput("slow_req_runs", 32'(req_runs.size()), 32'd2);
    foreach (req_runs[i]) checkOutput("slow_req_len", 32'(req_runs[i]), 32'd6);
    cfg_read(2'd0, r);
    checkOutput("slow_src_readback", r, 32'h3012);
    cfg_read(2'd1, r);
    checkOutput("slow_dst_readback", r, 32'd102);

    // Abort during the second request.
    $display("[TB] abort");
    base = n_writes;
    applyStimulus(32'h4000, 32'd200, 32'd5, 3, 32'd1);
    wait_writes(base + 1, 40);
    for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
    checkOutput("abort_in_req", 32'(mem_req), 32'd1);
    cfg_write(2'd3, 32'd2);
    exp_q.delete();
    cfg_read(2'd3, r);
    checkOutput("abort_ctrl", r, 32'd0);
    checkOutput("abort_irq", 32'(irq), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("abort_writes", 32'(n_writes - base), 32'd1);
    base = n_writes;
    applyStimulus(32'h5000, 32'd7, 32'd1, 0, 32'd5);
    wait_idle(30);
    checkOutput("ack_start_writes", 32'(n_writes - base), 32'd1);
    cfg_read(2'd3, r);
    checkOutput("ack_start_ctrl", r, 32'd2);

    // Asynchronous reset in the middle of a transfer.
    $display("[TB] reset mid-transfer");
    applyStimulus(32'h6100, 32'd300, 32'd10, 0, 32'd1);
    wait_writes(n_writes + 2, 40);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midreset_strobes", {29'd0, mem_req, tattr_wenable, irq}, 32'd0);
    checkOutput("midreset_tattr", {14'd0, tattr_addr, tattr_wdata}, 32'd0);
    checkOutput("midreset_mem_addr", mem_addr, 32'd0);
    base = n_writes;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_read(2'd3, r);
    checkOutput("midreset_ctrl", r, 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("midreset_writes", 32'(n_writes - base), 32'd0);

`ifdef TATTR_DMA_VBLANK_GATE_EN
    // Gated build: no request until vblank.
    $display("[TB] vblank gate");
    in_vblank = 1'b0;
    base = n_writes;
    applyStimulus(32'h7000, 32'd50, 32'd2, 0, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cfg_read(2'd3, r);
      checkOutput("gate_busy", 32'(r[0]), 32'd1);
      checkOutput("gate_no_req", 32'(mem_req), 32'd0);
    end
    in_vblank = 1'b1;
    wait_idle(40);
    checkOutput("gate_writes", 32'(n_writes - base), 32'd2);
`else
    // Default build: in_vblank has no effect.
    $display("[TB] vblank ignored");
    in_vblank = 1'b0;
    base = n_writes;
    applyStimulus(32'h7000, 32'd50, 32'd2, 0, 32'd1);
    wait_idle(20);
    checkOutput("novblank_writes", 32'(n_writes - base), 32'd2);
`endif
    checkOutput("model_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
